tinydfu_sysctl: RTL and testbench

Parametrised system-control block for TinyDFU board tops: turns a raw PLL lock indication into a sequenced set of synchronous resets and drives a mode-selectable status LED. It sits in the board top between the PLL/clock divider and the USB DFU core and PHY. It replaces the per-board free-running LED counter and 6-bit reset counter with one reusable block. It adds multiple reset channels with staggered release, re-entry on lock loss, and an activity-aware LED.

---
 rtl/tinydfu_sysctl.sv | 167 ++++++++++++++++
 tb/tb_tinydfu_sysctl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tinydfu_sysctl.sv
// tinydfu_sysctl: system-control block for TinyDFU board tops.
// Converts a raw PLL lock flag into a sequenced set of synchronous resets
// (with staggered, ascending release and re-entry on lock loss) and drives
// a mode-selectable status LED with heartbeat and activity blanking.
module tinydfu_sysctl #(
    parameter int N_RST       = 2,
    parameter int RST_HOLD    = 32,
    parameter int RST_STAGGER = 8,
    parameter int LED_DIV_W   = 21,
    parameter int ACT_HOLD    = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             act_pulse,
    input  logic [1:0]       led_mode,
    output logic [N_RST-1:0] rst_out,
    output logic             running,
    output logic             led
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = (RST_STAGGER > 0) ? $clog2(RST_STAGGER + 1) : 1;
    localparam int AW = $clog2(ACT_HOLD + 1);
    localparam int IW = (N_RST > 1) ? $clog2(N_RST) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] STAG_LAST = SW'(RST_STAGGER);
    localparam logic [AW-1:0] ACT_LOAD  = AW'(ACT_HOLD);
    localparam logic [IW-1:0] LAST_CH   = IW'(N_RST - 1);
    localparam bit            ALL_AT_ONCE = (N_RST == 1) || (RST_STAGGER == 0);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t               state;
    logic                 lk1;
    logic                 lk;
    logic [HW-1:0]        hold_cnt;
    logic [SW-1:0]        stag_cnt;
    logic [IW-1:0]        nxt;
    logic [LED_DIV_W-1:0] div;
    logic [AW-1:0]        act_cnt;
    logic                 hold_done;

    // Double-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk1 <= 1'b0;
            lk  <= 1'b0;
        end else begin
            lk1 <= pll_locked;
            lk  <= lk1;
        end
    end

    // Hold period ends on the edge where the RST_HOLD-th stable lock sample
    // is seen. HOLD is entered with the first sample already counted, so a
    // hold of one cycle leaves straight from WAIT_LOCK.
    always_comb begin
        hold_done = 1'b0;
        if (lk) begin
            if (state == WAIT_LOCK && RST_HOLD == 1)
                hold_done = 1'b1;
            else if (state == HOLD && hold_cnt == HOLD_LAST)
                hold_done = 1'b1;
        end
    end

    // Reset sequencer FSM with registered reset and running outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            stag_cnt <= '0;
            nxt      <= '0;
            rst_out  <= '1;
            running  <= 1'b0;
        end else if (state != WAIT_LOCK && !lk) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            stag_cnt <= '0;
            nxt      <= '0;
            rst_out  <= '1;
            running  <= 1'b0;
        end else if (hold_done) begin
            hold_cnt <= '0;
            if (ALL_AT_ONCE) begin
                rst_out <= '0;
                state   <= RUN;
                running <= 1'b1;
            end else begin
                rst_out[0] <= 1'b0;
                nxt        <= IW'(1);
                stag_cnt   <= SW'(1);
                state      <= RELEASE;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lk) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(1);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                RELEASE: begin
                    if (stag_cnt == STAG_LAST) begin
                        rst_out  <= rst_out & ~(N_RST'(1) << nxt);
                        stag_cnt <= SW'(1);
                        if (nxt == LAST_CH) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            nxt <= nxt + 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Free-running LED divider, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    // Retriggerable activity blanking counter, saturating at zero.
    always_ff @(posedge clk) begin
        if (reset)
            act_cnt <= '0;
        else if (act_pulse)
            act_cnt <= ACT_LOAD;
        else if (act_cnt != '0)
            act_cnt <= act_cnt - 1'b1;
    end

    // Registered LED drive: fast blink until running, then mode-selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= 1'b0;
        end else if (state != RUN) begin
            led <= div[LED_DIV_W-3];
        end else begin
            case (led_mode)
                2'd0:    led <= 1'b0;
                2'd1:    led <= 1'b1;
                2'd2:    led <= div[LED_DIV_W-1];
                default: led <= (act_cnt == '0);
            endcase
        end
    end

endmodule

// File: tb/tb_tinydfu_sysctl.sv
// Directed self-checking bench for tinydfu_sysctl: one default instance and
// one with N_RST=4, RST_HOLD=5, RST_STAGGER=0, LED_DIV_W=4, ACT_HOLD=16.
module tb_tinydfu_sysctl;

    logic       clk = 1'b0;
    logic       reset_a, pll_a, act_a;
    logic [1:0] mode_a;
    logic [1:0] rst_a;
    logic       run_a, led_a;
    logic       reset_b, pll_b, act_b;
    logic [1:0] mode_b;
    logic [3:0] rst_b;
    logic       run_b, led_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tinydfu_sysctl dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .pll_locked (pll_a),
        .act_pulse  (act_a),
        .led_mode   (mode_a),
        .rst_out    (rst_a),
        .running    (run_a),
        .led        (led_a)
    );

    tinydfu_sysctl #(
        .N_RST       (4),
        .RST_HOLD    (5),
        .RST_STAGGER (0),
        .LED_DIV_W   (4),
        .ACT_HOLD    (16)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .pll_locked (pll_b),
        .act_pulse  (act_b),
        .led_mode   (mode_b),
        .rst_out    (rst_b),
        .running    (run_b),
        .led        (led_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each call returns just after the falling edge following n rising edges.
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_a = 1'b1; pll_a = 1'b0; act_a = 1'b0; mode_a = 2'd1;
        reset_b = 1'b1; pll_b = 1'b0; act_b = 1'b0; mode_b = 2'd0;
        wait_n(3);
        chk("a_reset_rst", 32'(rst_a), 32'h3);
        chk("a_reset_run", 32'(run_a), 32'h0);
        chk("a_reset_led", 32'(led_a), 32'h0);
        chk("b_reset_rst", 32'(rst_b), 32'hF);
        chk("b_reset_run", 32'(run_b), 32'h0);

        // Default instance: lock seen at edge E; k waits observe after E+k-1.
        reset_a = 1'b0;
        pll_a   = 1'b1;
        wait_n(33);
        chk("a_hold_e32", 32'(rst_a), 32'h3);
        wait_n(1);
        chk("a_ch0_e33", 32'(rst_a), 32'h2);
        chk("a_run_e33", 32'(run_a), 32'h0);
        wait_n(7);
        chk("a_ch1_e40", 32'(rst_a), 32'h2);
        wait_n(1);
        chk("a_ch1_e41", 32'(rst_a), 32'h0);
        chk("a_run_e41", 32'(run_a), 32'h1);
        wait_n(1);
        chk("a_led_mode1", 32'(led_a), 32'h1);

        // One-cycle reset in RUN with lock stable, then full replay.
        reset_a = 1'b1;
        wait_n(1);
        chk("a_rstpulse_rst", 32'(rst_a), 32'h3);
        chk("a_rstpulse_run", 32'(run_a), 32'h0);
        chk("a_rstpulse_led", 32'(led_a), 32'h0);
        reset_a = 1'b0;
        wait_n(1);
        chk("a_replay_e0", 32'(rst_a), 32'h3);
        wait_n(32);
        chk("a_replay_e32", 32'(rst_a), 32'h3);
        wait_n(1);
        chk("a_replay_e33", 32'(rst_a), 32'h2);

        // Lock loss during RELEASE with only channel 0 released.
        pll_a = 1'b0;
        wait_n(2);
        chk("a_loss_f1", 32'(rst_a), 32'h2);
        wait_n(1);
        chk("a_loss_f2", 32'(rst_a), 32'h3);
        chk("a_loss_run", 32'(run_a), 32'h0);

        // Relock must count the whole hold period again.
        pll_a = 1'b1;
        wait_n(33);
        chk("a_relock_e32", 32'(rst_a), 32'h3);
        wait_n(1);
        chk("a_relock_e33", 32'(rst_a), 32'h2);
        wait_n(7);
        chk("a_relock_e40", 32'(rst_a), 32'h2);
        wait_n(1);
        chk("a_relock_e41", 32'(rst_a), 32'h0);
        chk("a_relock_run", 32'(run_a), 32'h1);

        // Second instance: reset edge R0, lock edge E=R0+1.
        reset_b = 1'b1;
        wait_n(1);
        reset_b = 1'b0;
        pll_b   = 1'b1;
        mode_b  = 2'd0;
        wait_n(1);
        chk("b_blink_r1", 32'(led_b), 32'h0);
        chk("b_rst_r1", 32'(rst_b), 32'hF);
        wait_n(2);
        chk("b_blink_r3", 32'(led_b), 32'h1);
        wait_n(2);
        chk("b_blink_r5", 32'(led_b), 32'h0);
        wait_n(1);
        chk("b_rst_e5", 32'(rst_b), 32'hF);
        chk("b_run_e5", 32'(run_b), 32'h0);
        wait_n(1);
        chk("b_rst_e6", 32'(rst_b), 32'h0);
        chk("b_run_e6", 32'(run_b), 32'h1);
        chk("b_blink_r7", 32'(led_b), 32'h1);

        // Heartbeat: after R0+k the led equals bit 3 of (k-1) mod 16.
        mode_b = 2'd2;
        wait_n(1);
        chk("b_hb_r8", 32'(led_b), 32'h0);
        wait_n(1);
        chk("b_hb_r9", 32'(led_b), 32'h1);
        wait_n(7);
        chk("b_hb_r16", 32'(led_b), 32'h1);
        wait_n(1);
        chk("b_hb_r17", 32'(led_b), 32'h0);
        wait_n(8);
        chk("b_hb_r25", 32'(led_b), 32'h1);

        mode_b = 2'd1;
        wait_n(1);
        chk("b_mode1", 32'(led_b), 32'h1);
        mode_b = 2'd0;
        wait_n(1);
        chk("b_mode0", 32'(led_b), 32'h0);
        mode_b = 2'd3;
        wait_n(1);
        chk("b_mode3_idle", 32'(led_b), 32'h1);

        // Activity: pulse at A, retrigger at A+10.
        act_b = 1'b1;
        wait_n(1);
        act_b = 1'b0;
        chk("b_act_a0", 32'(led_b), 32'h1);
        wait_n(1);
        chk("b_act_a1", 32'(led_b), 32'h0);
        wait_n(8);
        chk("b_act_a9", 32'(led_b), 32'h0);
        act_b = 1'b1;
        wait_n(1);
        act_b = 1'b0;
        chk("b_act_a10", 32'(led_b), 32'h0);
        wait_n(7);
        chk("b_act_a17", 32'(led_b), 32'h0);
        wait_n(9);
        chk("b_act_a26", 32'(led_b), 32'h0);
        wait_n(1);
        chk("b_act_a27", 32'(led_b), 32'h1);

        // Reset wins over a simultaneous activity pulse.
        reset_b = 1'b1;
        act_b   = 1'b1;
        wait_n(1);
        reset_b = 1'b0;
        act_b   = 1'b0;
        chk("b_prio_rst", 32'(rst_b), 32'hF);
        chk("b_prio_run", 32'(run_b), 32'h0);
        chk("b_prio_led", 32'(led_b), 32'h0);
        wait_n(6);
        chk("b_prio_e5", 32'(rst_b), 32'hF);
        wait_n(1);
        chk("b_prio_e6", 32'(rst_b), 32'h0);
        chk("b_prio_run6", 32'(run_b), 32'h1);
        wait_n(1);
        chk("b_prio_act_clear", 32'(led_b), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
